// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the round-robin arbiter in front of the 4:1 mux.
package mux_arb_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Round-robin pick: scan ptr, ptr+1, ... (mod N_REQ) and return {found, index}.
    // The scan runs from the far end back towards ptr, so the closest requester wins.
    function automatic logic [SEL_W:0] rr_pick(input logic [N_REQ-1:0] req,
                                               input logic [SEL_W-1:0] ptr);
        logic [SEL_W:0]   result;
        logic [SEL_W-1:0] idx;
        result = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = ptr + SEL_W'(k);
            if (req[idx]) begin
                result = {1'b1, idx};
            end
        end
        return result;
    endfunction

    // One-hot grant vector for a requester index.
    function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        return N_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/mux_4_1.sv
// Plain 4:1 single-bit multiplexer forming the shared datapath.
module mux_4_1 (
    input  logic       i0,
    input  logic       i1,
    input  logic       i2,
    input  logic       i3,
    input  logic [1:0] s,
    output logic       y
);

    // Route the selected input straight through.
    always_comb begin
        y = i0;
        case (s)
            2'd0:    y = i0;
            2'd1:    y = i1;
            2'd2:    y = i2;
            default: y = i3;
        endcase
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 mux among four requesters. A grant lasts
// until the owner withdraws or completes MAX_HOLD accepted transfers; on release
// the next owner is chosen in the same edge, starting just after the old one.
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] in_data,
    output logic [N_REQ-1:0] gnt,
    output logic [SEL_W-1:0] sel,
    output logic             out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    arb_state_t       state;
    logic [SEL_W-1:0] ptr;
    logic [7:0]       hold_cnt;

    logic             req_sel;
    logic             transfer;
    logic             last_xfer;
    logic             release_now;
    logic [SEL_W-1:0] ptr_next;
    logic [SEL_W:0]   pick_idle;
    logic [SEL_W:0]   pick_rel;

    // Handshake and release decisions are derived from the registered grant,
    // so sel/gnt only move on release edges.
    assign req_sel     = req[sel];
    assign busy        = (state == GRANT);
    assign out_valid   = busy && req_sel;
    assign transfer    = out_valid && out_ready;
    assign last_xfer   = transfer && (hold_cnt == 8'(MAX_HOLD - 1));
    assign release_now = busy && (!req_sel || last_xfer);

    // The released owner drops to lowest priority by restarting the scan after it.
    assign ptr_next  = sel + SEL_W'(1);
    assign pick_idle = rr_pick(req, ptr);
    assign pick_rel  = rr_pick(req, ptr_next);

    // Arbiter FSM: grant on request, hold for the burst, re-arbitrate without a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt      <= '0;
            sel      <= '0;
            ptr      <= '0;
            hold_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_idle[SEL_W]) begin
                        state    <= GRANT;
                        gnt      <= onehot(pick_idle[SEL_W-1:0]);
                        sel      <= pick_idle[SEL_W-1:0];
                        hold_cnt <= '0;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        ptr      <= ptr_next;
                        hold_cnt <= '0;
                        if (pick_rel[SEL_W]) begin
                            gnt <= onehot(pick_rel[SEL_W-1:0]);
                            sel <= pick_rel[SEL_W-1:0];
                        end else begin
                            state <= IDLE;
                            gnt   <= '0;
                        end
                    end else if (transfer) begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                end
            endcase
        end
    end

    // Shared datapath: requester i feeds mux input i.
    mux_4_1 u_mux (
        .i0 (in_data[0]),
        .i1 (in_data[1]),
        .i2 (in_data[2]),
        .i3 (in_data[3]),
        .s  (sel),
        .y  (out_data)
    );

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: two instances (MAX_HOLD 8 and 2) share stimulus and
// are compared every cycle against a queue-free ownership model, plus a vector
// table and directed sequences for the multi-cycle corner cases.
module tb_mux_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] in_data;
    logic       out_ready;

    logic [3:0] gnt_a, gnt_b;
    logic [1:0] sel_a, sel_b;
    logic       data_a, data_b, valid_a, valid_b, busy_a, busy_b;

    always #5 clk = ~clk;

    mux_rr_arbiter #(.MAX_HOLD(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .req(req), .in_data(in_data),
        .gnt(gnt_a), .sel(sel_a), .out_data(data_a), .out_valid(valid_a),
        .out_ready(out_ready), .busy(busy_a)
    );

    mux_rr_arbiter #(.MAX_HOLD(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req), .in_data(in_data),
        .gnt(gnt_b), .sel(sel_b), .out_data(data_b), .out_valid(valid_b),
        .out_ready(out_ready), .busy(busy_b)
    );

    int errors = 0;
    int checks = 0;

    // Model: who owns the mux (-1 = nobody), last select, scan start, transfers so far.
    int m_owner[2];
    int m_sel[2];
    int m_ptr[2];
    int m_cnt[2];
    int max_hold[2] = '{8, 2};

    typedef struct {
        logic [3:0] req;
        logic [3:0] din;
        logic       rdy;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       valid;
        logic       data;
        logic       busy;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_owner[i] = -1;
            m_sel[i]   = 0;
            m_ptr[i]   = 0;
            m_cnt[i]   = 0;
        end
    endtask

    task automatic model_step(input int i);
        int w;
        bit done;
        if (m_owner[i] < 0) begin
            w = pick(req, m_ptr[i]);
            if (w >= 0) begin
                m_owner[i] = w; m_sel[i] = w; m_cnt[i] = 0;
            end
        end else begin
            done = 1'b0;
            if (!req[m_owner[i]]) begin
                done = 1'b1;
            end else if (out_ready) begin
                m_cnt[i]++;
                if (m_cnt[i] == max_hold[i]) done = 1'b1;
            end
            if (done) begin
                m_ptr[i] = (m_owner[i] + 1) % 4;
                w = pick(req, m_ptr[i]);
                if (w >= 0) begin
                    m_owner[i] = w; m_sel[i] = w; m_cnt[i] = 0;
                end else begin
                    m_owner[i] = -1;
                end
            end
        end
    endtask

    task automatic check_model(input int i, input string tag, input logic [3:0] g,
                               input logic [1:0] s, input logic v, input logic d, input logic b);
        int o;
        logic ev;
        o  = m_owner[i];
        ev = 1'b0;
        if (o >= 0) ev = req[o];
        check({tag, "_gnt"},   8'(g), (o < 0) ? 8'h00 : 8'(1 << o));
        check({tag, "_sel"},   8'(s), 8'(m_sel[i]));
        check({tag, "_valid"}, 8'(v), 8'(ev));
        check({tag, "_data"},  8'(d), 8'(in_data[m_sel[i]]));
        check({tag, "_busy"},  8'(b), 8'(o >= 0));
    endtask

    task automatic check_both();
        check_model(0, "a", gnt_a, sel_a, valid_a, data_a, busy_a);
        check_model(1, "b", gnt_b, sel_b, valid_b, data_b, busy_b);
    endtask

    // Called at a falling edge with inputs already driven.
    task automatic cycle();
        #1;
        check_both();
        @(posedge clk);
        model_step(0);
        model_step(1);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_both();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [3:0] fair_exp[10];

    initial begin
        vecs[0]  = '{4'b0100, 4'b0100, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{4'b0100, 4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b1, 1'b1};
        vecs[2]  = '{4'b0100, 4'b0000, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b1};
        vecs[3]  = '{4'b0100, 4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b1, 1'b1};
        vecs[4]  = '{4'b0000, 4'b0100, 1'b1, 4'b0100, 2'd2, 1'b0, 1'b1, 1'b1};
        vecs[5]  = '{4'b0000, 4'b0100, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{4'b1001, 4'b1000, 1'b0, 4'b0000, 2'd2, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{4'b1001, 4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b1, 1'b1};
        vecs[8]  = '{4'b0001, 4'b1001, 1'b1, 4'b1000, 2'd3, 1'b0, 1'b1, 1'b1};
        vecs[9]  = '{4'b0001, 4'b0001, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b1, 1'b1};
        vecs[10] = '{4'b0000, 4'b0000, 1'b0, 4'b0001, 2'd0, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0};

        fair_exp = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100,
                     4'b0100, 4'b1000, 4'b1000, 4'b0001, 4'b0001};

        // Reset with every requester active: outputs must sit at reset values.
        rst_n     = 1'b0;
        req       = 4'b1111;
        in_data   = 4'b0000;
        out_ready = 1'b1;
        #1;
        model_reset();
        check_both();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Vector table on the MAX_HOLD=8 instance.
        for (int r = 0; r < 12; r++) begin
            req       = vecs[r].req;
            in_data   = vecs[r].din;
            out_ready = vecs[r].rdy;
            #1;
            check($sformatf("vec%0d_gnt", r),   8'(gnt_a),   8'(vecs[r].gnt));
            check($sformatf("vec%0d_sel", r),   8'(sel_a),   8'(vecs[r].sel));
            check($sformatf("vec%0d_valid", r), 8'(valid_a), 8'(vecs[r].valid));
            check($sformatf("vec%0d_data", r),  8'(data_a),  8'(vecs[r].data));
            check($sformatf("vec%0d_busy", r),  8'(busy_a),  8'(vecs[r].busy));
            $display("vec %0d: req=%b rdy=%b gnt=%b sel=%0d valid=%b data=%b busy=%b",
                     r, req, out_ready, gnt_a, sel_a, valid_a, data_a, busy_a);
            cycle();
        end

        // Single requester: 8-transfer burst, self re-grant with a fresh count.
        req       = 4'b0100;
        out_ready = 1'b1;
        cycle();
        for (int k = 0; k < 8; k++) begin
            check("single_gnt", 8'(gnt_a), 8'h04);
            in_data = 4'($urandom);
            cycle();
        end
        req = 4'b0101;
        for (int k = 0; k < 8; k++) begin
            check("regrant_gnt", 8'(gnt_a), 8'h04);
            cycle();
        end
        check("regrant_release_gnt", 8'(gnt_a), 8'h01);
        $display("single req burst: gnt after second burst=%b", gnt_a);

        // Fairness on the MAX_HOLD=2 instance.
        do_reset();
        req       = 4'b1111;
        out_ready = 1'b1;
        cycle();
        for (int k = 0; k < 10; k++) begin
            check($sformatf("fair%0d_gnt", k), 8'(gnt_b), 8'(fair_exp[k]));
            $display("fairness step %0d: gnt=%b", k, gnt_b);
            cycle();
        end

        // Backpressure: grant to 1 stalls for 20 cycles, then exactly 8 transfers.
        do_reset();
        req       = 4'b1010;
        out_ready = 1'b0;
        cycle();
        for (int k = 0; k < 20; k++) begin
            check("stall_gnt", 8'(gnt_a), 8'h02);
            check("stall_valid", 8'(valid_a), 8'h01);
            cycle();
        end
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check("resume_gnt", 8'(gnt_a), 8'h02);
            cycle();
        end
        check("resume_release_gnt", 8'(gnt_a), 8'h08);
        $display("backpressure: gnt after resume=%b", gnt_a);

        // Reset mid-burst with hold count at 5, then first grant scans from 0.
        do_reset();
        req       = 4'b0100;
        out_ready = 1'b1;
        cycle();
        for (int k = 0; k < 5; k++) cycle();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("midrst_gnt", 8'(gnt_a), 8'h00);
        check("midrst_sel", 8'(sel_a), 8'h00);
        check("midrst_valid", 8'(valid_a), 8'h00);
        check("midrst_busy", 8'(busy_a), 8'h00);
        check_both();
        @(negedge clk);
        req   = 4'b1000;
        rst_n = 1'b1;
        cycle();
        check("postrst_gnt", 8'(gnt_a), 8'h08);
        check("postrst_sel", 8'(sel_a), 8'h03);
        $display("reset mid-burst: first grant after release gnt=%b", gnt_a);

        // Random traffic against the model.
        do_reset();
        req = 4'($urandom);
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom);
            in_data   = 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
